hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_unit_forward_sel.sv | 26 ++
 rtl/hazard_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit and its
// operand-forwarding selectors.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic [1:0] {
      RUN  = 2'b00,
      WAIT = 2'b01,
      ERR  = 2'b10
   } hz_state_t;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_unit_forward_sel.sv
// Operand forwarding select for one Execute-stage source register.
// The Memory stage holds the younger result, so it takes priority.
module forward_sel
   import hazard_pkg::*;
(
   input  logic       RegWriteM,
   input  logic [4:0] RdM,
   input  logic       RegWriteW,
   input  logic [4:0] RdW,
   input  logic [4:0] RsE,
   output logic [1:0] Fwd
);

   fwd_sel_t w_sel;

   always_comb begin
      w_sel = FWD_RF;
      if (RegWriteM && (RdM != 5'd0) && (RdM == RsE))
         w_sel = FWD_MEM;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == RsE))
         w_sel = FWD_WB;
   end

   assign Fwd = w_sel;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush and a
// data-memory wait watchdog that latches a timeout error until reset.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int MAX_WAIT = 15
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [1:0] ResultSrcE,
   input  logic       PCSrcE,
   input  logic       RegWriteM,
   input  logic [4:0] RdM,
   input  logic       RegWriteW,
   input  logic [4:0] RdW,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic       MemTimeout
);

   localparam logic [8:0] W_MAX = 9'(MAX_WAIT);

   hz_state_t  r_state;
   hz_state_t  w_state_next;
   logic [7:0] r_wait_cnt;
   logic [7:0] w_wait_cnt_next;
   logic [1:0] w_fwd_a;
   logic [1:0] w_fwd_b;
   logic       w_lw_stall;
   logic       w_mem_stall;

   forward_sel u_fwd_a (
      .RegWriteM (RegWriteM),
      .RdM       (RdM),
      .RegWriteW (RegWriteW),
      .RdW       (RdW),
      .RsE       (Rs1E),
      .Fwd       (w_fwd_a)
   );

   forward_sel u_fwd_b (
      .RegWriteM (RegWriteM),
      .RdM       (RdM),
      .RegWriteW (RegWriteW),
      .RdW       (RdW),
      .RsE       (Rs2E),
      .Fwd       (w_fwd_b)
   );

   assign w_lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));
   assign w_mem_stall = MemReqM && !MemReadyM;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= RUN;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_wait_cnt_next = r_wait_cnt;
      case (r_state)
         RUN: begin
            w_wait_cnt_next = 8'd0;
            if (w_mem_stall)
               w_state_next = WAIT;
         end
         WAIT: begin
            if (MemReadyM) begin
               w_state_next    = RUN;
               w_wait_cnt_next = 8'd0;
            end else begin
               // The RUN cycle that raised the stall counts too, so the
               // watchdog fires on stalled cycle MAX_WAIT+1.
               if (w_mem_stall && (({1'b0, r_wait_cnt} + 9'd1) >= W_MAX))
                  w_state_next = ERR;
               if (r_wait_cnt != 8'hFF)
                  w_wait_cnt_next = r_wait_cnt + 8'd1;
            end
         end
         ERR:     w_state_next = ERR;
         default: w_state_next = RUN;
      endcase
   end

   // A branch held during a memory stall is frozen by StallE and flushed
   // as soon as the stall drops, since the flush terms follow live inputs.
   always_comb begin
      ForwardAE  = w_fwd_a;
      ForwardBE  = w_fwd_b;
      StallF     = 1'b0;
      StallD     = 1'b0;
      StallE     = 1'b0;
      StallM     = 1'b0;
      FlushD     = 1'b0;
      FlushE     = 1'b0;
      FlushW     = 1'b0;
      MemTimeout = 1'b0;
      if (rst) begin
         ForwardAE = FWD_RF;
         ForwardBE = FWD_RF;
         FlushD    = 1'b1;
         FlushE    = 1'b1;
         FlushW    = 1'b1;
      end else if (r_state == ERR) begin
         StallF     = 1'b1;
         StallD     = 1'b1;
         StallE     = 1'b1;
         StallM     = 1'b1;
         FlushW     = 1'b1;
         MemTimeout = 1'b1;
      end else begin
         StallF = w_lw_stall || w_mem_stall;
         StallD = w_lw_stall || w_mem_stall;
         StallE = w_mem_stall;
         StallM = w_mem_stall;
         FlushW = w_mem_stall;
         FlushD = PCSrcE && !w_mem_stall;
         FlushE = (w_lw_stall || PCSrcE) && !w_mem_stall;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: a behavioural model pushes the expected
// output vector each cycle and it is popped and compared mid-cycle.
module tb_hazard_unit;

   localparam int MAXW = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0] ResultSrcE;
   logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushW, MemTimeout;

   int errors = 0;
   int checks = 0;

   // model state: consecutive stalled cycles and sticky error
   int m_cnt = 0;
   bit m_err = 0;
   logic [11:0] exp_q[$];

   hazard_unit #(.MAX_WAIT(MAXW)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .MemTimeout(MemTimeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got fA=%b fB=%b stl=%b fl=%b to=%b, need fA=%b fB=%b stl=%b fl=%b to=%b",
                  tag, got[11:10], got[9:8], got[7:4], got[3:1], got[0],
                  exp[11:10], exp[9:8], exp[7:4], exp[3:1], exp[0]);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [11:0] m_expect();
      logic lw, ms, sfd, se, fd, fe, fw, to;
      logic [1:0] fa, fb;
      lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      ms = MemReqM && !MemReadyM;
      fa = m_fwd(Rs1E);
      fb = m_fwd(Rs2E);
      if (rst) begin
         fa = 0; fb = 0; sfd = 0; se = 0; fd = 1; fe = 1; fw = 1; to = 0;
      end else if (m_err) begin
         sfd = 1; se = 1; fd = 0; fe = 0; fw = 1; to = 1;
      end else begin
         sfd = lw | ms; se = ms; fw = ms;
         fd = PCSrcE & ~ms; fe = (lw | PCSrcE) & ~ms; to = 0;
      end
      return {fa, fb, sfd, sfd, se, se, fd, fe, fw, to};
   endfunction

   // one bus cycle: push expectation, compare mid-cycle, advance model at the edge
   task automatic step(input string tag);
      logic [11:0] exp;
      logic [11:0] got;
      exp_q.push_back(m_expect());
      @(negedge clk);
      got = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
             FlushD, FlushE, FlushW, MemTimeout};
      exp = exp_q.pop_front();
      $display("t=%0t %s rst=%b req=%b rdy=%b pc=%b out=%b", $time, tag, rst,
               MemReqM, MemReadyM, PCSrcE, got);
      chk(tag, got, exp);
      if (rst) begin
         m_cnt = 0; m_err = 0;
      end else if (!m_err) begin
         if (MemReqM && !MemReadyM) begin
            m_cnt++;
            if (m_cnt == MAXW + 1) m_err = 1;
         end else begin
            m_cnt = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      ResultSrcE = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0;
      MemReqM = 0; MemReadyM = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      RdM = 5; RegWriteM = 1; Rs1E = 5; MemReqM = 1; PCSrcE = 1;
      step("reset0");
      step("reset1");
      idle();
      rst = 0;

      RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
      step("fwdA_mem");
      RdM = 0; RdW = 0; Rs1E = 0;
      step("fwd_x0");
      RdM = 3; RegWriteM = 0; RdW = 3; Rs1E = 3; Rs2E = 3;
      step("fwd_wb");
      RegWriteM = 1; Rs1E = 4; RdW = 4;
      step("fwdB_mem_A_wb");
      idle();

      ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
      step("lw_stall");
      idle();
      step("lw_done");

      MemReqM = 1;
      for (int i = 0; i < 3; i++) step("mem_wait");
      MemReadyM = 1;
      step("mem_ready");
      idle();
      step("mem_after");

      MemReqM = 1; PCSrcE = 1;
      for (int i = 0; i < 2; i++) step("br_in_stall");
      MemReadyM = 1;
      step("br_release");
      idle();

      ResultSrcE = 2'b01; RdE = 9; Rs1D = 9; PCSrcE = 1;
      step("lw_and_branch");
      idle();
      MemReqM = 1; MemReadyM = 1;
      step("mem_same_cycle");
      MemReadyM = 0;
      step("mem_stall_fresh");
      MemReadyM = 1;
      step("mem_fresh_ready");
      idle();

      MemReqM = 1; RdM = 6; RegWriteM = 1; Rs2E = 6;
      for (int i = 0; i < 7; i++) step("timeout_run");
      MemReadyM = 1;
      step("timeout_sticky");
      rst = 1;
      step("timeout_rst");
      rst = 0; idle();
      step("timeout_clear");

      MemReqM = 1;
      step("wait_enter");
      step("wait_hold");
      rst = 1;
      step("wait_rst");
      rst = 0; PCSrcE = 1;
      step("wait_rst_live");
      MemReadyM = 1;
      step("wait_rst_ready");
      idle();

      for (int n = 0; n < 200; n++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         ResultSrcE = 2'($urandom_range(0, 3));
         PCSrcE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
         MemReqM = ($urandom_range(0, 3) != 0);
         MemReadyM = ($urandom_range(0, 2) == 0);
         if (m_cnt > 0 && !(MemReqM && !MemReadyM)) MemReadyM = 1;
         rst = ($urandom_range(0, 39) == 0);
         step("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
